joy_serializer: RTL and testbench

- Transmit end of the serial joystick link: emulates the board's parallel-in/serial-out shift chain that the joystick decoder reads.
- Captures two 6-button joysticks and shifts them out one bit per rising edge of the externally supplied joy_clk_i, under an active-low joy_load_i.
- Used as a bench/loopback source for the decoder and as the on-board serializer in builds with local joystick pins.
- All link inputs are asynchronous to clk and are synchronised and glitch-filtered internally.

---
 rtl/joy_link_pkg.sv | 59 +++++
 rtl/joy_serializer_sync_filter.sv | 54 +++++
 rtl/joy_serializer.sv | 143 ++++++++++++++
 tb/tb_joy_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/joy_link_pkg.sv
// ----------------------------------------------------------------------------
// joy_link_pkg
// Shared definitions for the serial joystick link transmit path.
//   - link_state_t : serializer sequencing states
//   - frame layout : where each joystick lands in the shifted frame
//   - button index : position of each button inside a 6-bit joystick word
//   - build_core_frame : packs two joysticks into the 16-bit frame core
// ----------------------------------------------------------------------------
package joy_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } link_state_t;

  localparam int DEFAULT_FRAME_BITS = 16;
  localparam int CORE_FRAME_BITS    = 16;

  localparam int NUM_BTNS  = 6;
  localparam int JOY1_BASE = 0;
  localparam int JOY2_BASE = 8;
  // Idle-high bits that follow each joystick group inside the core frame.
  localparam int PAD_BITS  = 2;

  // Bit index of each button in joy*_i, which is also its shift order.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE1 = 4;
  localparam int BTN_FIRE2 = 5;

  // Buttons are active-high on the pins but active-low on the wire.
  function automatic logic [CORE_FRAME_BITS-1:0] build_core_frame(
    input logic [NUM_BTNS-1:0] joy1,
    input logic [NUM_BTNS-1:0] joy2
  );
    logic [CORE_FRAME_BITS-1:0] f;
    f = '1;
    f[JOY1_BASE + BTN_UP]    = ~joy1[BTN_UP];
    f[JOY1_BASE + BTN_DOWN]  = ~joy1[BTN_DOWN];
    f[JOY1_BASE + BTN_LEFT]  = ~joy1[BTN_LEFT];
    f[JOY1_BASE + BTN_RIGHT] = ~joy1[BTN_RIGHT];
    f[JOY1_BASE + BTN_FIRE1] = ~joy1[BTN_FIRE1];
    f[JOY1_BASE + BTN_FIRE2] = ~joy1[BTN_FIRE2];
    f[JOY2_BASE + BTN_UP]    = ~joy2[BTN_UP];
    f[JOY2_BASE + BTN_DOWN]  = ~joy2[BTN_DOWN];
    f[JOY2_BASE + BTN_LEFT]  = ~joy2[BTN_LEFT];
    f[JOY2_BASE + BTN_RIGHT] = ~joy2[BTN_RIGHT];
    f[JOY2_BASE + BTN_FIRE1] = ~joy2[BTN_FIRE1];
    f[JOY2_BASE + BTN_FIRE2] = ~joy2[BTN_FIRE2];
    f[JOY1_BASE + NUM_BTNS +: PAD_BITS] = '1;
    f[JOY2_BASE + NUM_BTNS +: PAD_BITS] = '1;
    return f;
  endfunction

endpackage

// File: rtl/joy_serializer_sync_filter.sv
// ----------------------------------------------------------------------------
// sync_filter
// Brings one asynchronous link input into the clk domain and rejects glitches.
// A 2-flop synchroniser feeds a stability filter: the filtered level only
// follows the synchronised level once they have differed for FILTER
// consecutive cycles. Pin-to-filtered latency is 2+FILTER cycles.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   i_async  in   raw asynchronous input
//   o_filt   out  synchronised, filtered level (resets to RST_VAL)
// ----------------------------------------------------------------------------
module sync_filter #(
  parameter int   FILTER  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_filt
);

  // Down-counter reload; reaching zero while still different accepts the level.
  localparam logic [3:0] TC_RELOAD = 4'(FILTER - 1);

  logic       r_meta;
  logic       r_sync;
  logic       r_filt;
  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_filt <= RST_VAL;
      r_cnt  <= TC_RELOAD;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      if (r_sync == r_filt) begin
        r_cnt <= TC_RELOAD;
      end else if (r_cnt == 4'd0) begin
        r_filt <= r_sync;
        r_cnt  <= TC_RELOAD;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/joy_serializer.sv
// ----------------------------------------------------------------------------
// joy_serializer
// Transmit end of the serial joystick link. Emulates a parallel-in/serial-out
// shift chain: while the decoder holds load low the two joysticks are
// captured, then each rising edge of the decoder's shift clock moves the
// frame one bit towards joy_data_o.
//
// state | meaning
// IDLE  | no frame; line idles high, waiting for load low
// LOAD  | load low; frame re-captured from the joystick pins every cycle
// SHIFT | frame in flight; each filtered joy_clk rise shifts one bit
// DONE  | frame fully shifted; line high, clock edges ignored
//
// Ports:
//   clk           in   system clock (48 MHz)
//   reset         in   asynchronous active-high reset
//   joy1_i[5:0]   in   joystick 1 {fire2,fire1,right,left,down,up}, 1 = pressed
//   joy2_i[5:0]   in   joystick 2, same order
//   joy_clk_i     in   link shift clock, asynchronous
//   joy_load_i    in   link load strobe, active-low, asynchronous
//   joy_data_o    out  serial data, buttons active-low
//   frame_done_o  out  one-cycle pulse after the last frame bit is shifted out
//   busy_o        out  high in LOAD or SHIFT
// ----------------------------------------------------------------------------
module joy_serializer
  import joy_link_pkg::*;
#(
  parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
  parameter int FILTER     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] joy1_i,
  input  logic [NUM_BTNS-1:0] joy2_i,
  input  logic                joy_clk_i,
  input  logic                joy_load_i,
  output logic                joy_data_o,
  output logic                frame_done_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

  link_state_t           r_state;
  link_state_t           w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [FRAME_BITS-1:0] w_frame;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  r_frame_done;
  logic                  w_done_nxt;
  logic                  r_clk_d;
  logic                  w_clk_f;
  logic                  w_load_f;
  logic                  w_clk_rise;

  sync_filter #(
    .FILTER  (FILTER),
    .RST_VAL (1'b0)
  ) u_sync_clk (
    .clk     (clk),
    .reset   (reset),
    .i_async (joy_clk_i),
    .o_filt  (w_clk_f)
  );

  sync_filter #(
    .FILTER  (FILTER),
    .RST_VAL (1'b1)
  ) u_sync_load (
    .clk     (clk),
    .reset   (reset),
    .i_async (joy_load_i),
    .o_filt  (w_load_f)
  );

  assign w_clk_rise = w_clk_f & ~r_clk_d;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  // Frame bits beyond the 16-bit core idle high.
  always_comb begin
    w_frame = '1;
    w_frame[CORE_FRAME_BITS-1:0] = build_core_frame(joy1_i, joy2_i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_load_f) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_shift_nxt = w_frame;
        w_cnt_nxt   = '0;
        if (w_load_f) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        // Load low takes priority, so a coincident clock rise never shifts.
        if (!w_load_f) begin
          w_state_nxt = LOAD;
        end else if (w_clk_rise) begin
          w_shift_nxt = {1'b1, r_shift[FRAME_BITS-1:1]};
          if (r_cnt != CNT_LAST) w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_LAST) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (!w_load_f) w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '1;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
      r_clk_d      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_done_nxt;
      r_clk_d      <= w_clk_f;
    end
  end

  assign joy_data_o   = r_shift[0];
  assign frame_done_o = r_frame_done;
  assign busy_o       = (r_state == LOAD) || (r_state == SHIFT);

endmodule

// File: tb/tb_joy_serializer.sv
`timescale 1ns/1ps
module tb_joy_serializer;

  localparam int FB   = 16;
  localparam int FILT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] joy1_i = 6'd0;
  logic [5:0] joy2_i = 6'd0;
  logic       joy_clk_i = 1'b0;
  logic       joy_load_i = 1'b1;
  logic       joy_data_o;
  logic       frame_done_o;
  logic       busy_o;

  joy_serializer #(.FRAME_BITS(FB), .FILTER(FILT)) dut (
    .clk          (clk),
    .reset        (reset),
    .joy1_i       (joy1_i),
    .joy2_i       (joy2_i),
    .joy_clk_i    (joy_clk_i),
    .joy_load_i   (joy_load_i),
    .joy_data_o   (joy_data_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: one expected line level per rising edge of joy_clk_i.
  bit exp_q[$];

  // Reference model: frame as a bit list plus the index of the bit on the line.
  bit model_frame [FB];
  int model_idx = FB;
  int exp_done  = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_bit(input logic [5:0] j1, input logic [5:0] j2, input int k);
    if (k < 6) return !j1[k];
    if (k >= 8 && k < 14) return !j2[k-8];
    return 1'b1;
  endfunction

  function automatic bit cur_exp();
    return (model_idx < FB) ? model_frame[model_idx] : 1'b1;
  endfunction

  task automatic model_load(input logic [5:0] j1, input logic [5:0] j2);
    for (int k = 0; k < FB; k++) model_frame[k] = ref_bit(j1, j2, k);
    model_idx = 0;
  endtask

  // Caller is at a falling clk edge.
  task automatic do_load(input logic [5:0] j1, input logic [5:0] j2);
    joy1_i = j1;
    joy2_i = j2;
    joy_load_i = 1'b0;
    repeat (8) @(negedge clk);
    joy_load_i = 1'b1;
    model_load(j1, j2);
    repeat (8) @(negedge clk);
  endtask

  // A pulse held for at least FILT cycles is a real shift edge.
  task automatic clk_pulse(input int hi, input int lo);
    exp_q.push_back(cur_exp());
    joy_clk_i = 1'b1;
    repeat (hi) @(negedge clk);
    joy_clk_i = 1'b0;
    if (hi >= FILT && model_idx < FB) begin
      model_idx++;
      if (model_idx == FB) exp_done++;
    end
    repeat (lo) @(negedge clk);
  endtask

  // Monitor: the decoder samples the line as it raises its shift clock.
  always @(posedge joy_clk_i) begin
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL serial_bit: unscheduled edge, got %0b expected none", joy_data_o);
    end else begin
      check("serial_bit", 32'(joy_data_o), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) if (frame_done_o) done_seen++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] nj1;
    logic [5:0] nj2;
    bit         old_bit;

    repeat (3) @(negedge clk);
    check("rst_data", 32'(joy_data_o), 32'(1));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_done", 32'(frame_done_o), 32'(0));
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 1: joy1 up only
    do_load(6'b000001, 6'b000000);
    check("t1_busy_shift", 32'(busy_o), 32'(1));
    repeat (FB) clk_pulse(8, 8);
    repeat (4) @(negedge clk);
    check("t1_done_count", 32'(done_seen), 32'(exp_done));
    check("t1_busy_after", 32'(busy_o), 32'(0));

    // 2: joy2 fire2 only, then extra edges in DONE
    do_load(6'b000000, 6'b100000);
    repeat (FB) clk_pulse(8, 8);
    repeat (4) clk_pulse(8, 8);
    check("t2_done_count", 32'(done_seen), 32'(exp_done));
    check("t2_busy_after", 32'(busy_o), 32'(0));

    // 3: abort after 5 edges, new frame with joy1 down
    a = 6'($urandom); b = 6'($urandom);
    do_load(a, b);
    repeat (5) clk_pulse(8, 8);
    b = 6'($urandom);
    do_load(6'b000010, b);
    check("t3_busy_reload", 32'(busy_o), 32'(1));
    repeat (FB) clk_pulse(8, 8);
    check("t3_done_count", 32'(done_seen), 32'(exp_done));

    // 4: glitch rejection
    a = 6'($urandom); b = 6'($urandom);
    do_load(a, b);
    repeat (3) clk_pulse(8, 8);
    clk_pulse(1, 8);
    check("t4_glitch_hold", 32'(joy_data_o), 32'(cur_exp()));
    clk_pulse(3, 8);
    check("t4_pulse3_shift", 32'(joy_data_o), 32'(cur_exp()));
    while (model_idx < FB) clk_pulse(8, 8);
    check("t4_done_count", 32'(done_seen), 32'(exp_done));

    // 5: load fall and clock rise land together
    b = 6'($urandom);
    do_load(6'b010101, b);
    repeat (2) clk_pulse(8, 8);
    old_bit = cur_exp();
    nj1 = 6'($urandom) & 6'b111110;
    nj2 = 6'($urandom);
    exp_q.push_back(old_bit);
    joy1_i = nj1;
    joy2_i = nj2;
    joy_load_i = 1'b0;
    joy_clk_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_shift", 32'(joy_data_o), 32'(old_bit));
    check("t5_busy_load", 32'(busy_o), 32'(1));
    @(posedge clk);
    #1;
    check("t5_new_k0", 32'(joy_data_o), 32'(ref_bit(nj1, nj2, 0)));
    @(negedge clk);
    joy_clk_i = 1'b0;
    repeat (6) @(negedge clk);
    joy_load_i = 1'b1;
    model_load(nj1, nj2);
    repeat (8) @(negedge clk);
    repeat (FB) clk_pulse(8, 8);
    check("t5_done_count", 32'(done_seen), 32'(exp_done));

    // 6: reset mid-frame
    a = 6'($urandom) | 6'b000001; b = 6'($urandom);
    do_load(a, b);
    repeat (7) clk_pulse(8, 8);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_data", 32'(joy_data_o), 32'(1));
    check("t6_rst_busy", 32'(busy_o), 32'(0));
    model_idx = FB;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    repeat (3) clk_pulse(8, 8);
    check("t6_idle_busy", 32'(busy_o), 32'(0));
    check("t6_done_count", 32'(done_seen), 32'(exp_done));

    // Random frames with varied shift timing
    for (int r = 0; r < 4; r++) begin
      a = 6'($urandom); b = 6'($urandom);
      do_load(a, b);
      for (int k = 0; k < FB; k++) clk_pulse($urandom_range(3, 6), $urandom_range(3, 6));
      repeat (6) @(negedge clk);
      check("rand_done_count", 32'(done_seen), 32'(exp_done));
      check("rand_busy_after", 32'(busy_o), 32'(0));
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
